id_stage_hs: RTL and testbench
==============================

# id_stage_hs

Parametrised decode-stage pipeline register with valid/ready handshake, generalised multi-source operand forwarding select, load-use stall/bubble insertion and flush. Sits between the IF/ID register and EX. The parent instantiates `decoder` and `regfile` and feeds their outputs in. This block owns the ID/EX register and all hazard decisions that were previously fixed to two forwarding sources with no back-pressure.

## Interface

Parameters:
- `XLEN`, 32: data and PC width.
- `RF_AW`, 5: register address width.
- `FWD_EXT`, 2: number of external forwarding sources (index 0 = youngest, e.g. MEM; 1 = WB). Must be ≥1.
- `CTRL_W`, 32: width of the opaque decoded-control bundle passed through.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `id_flush`  in  1  kill the ID-stage instruction.
- `if2id_valid`  in  1  upstream instruction valid.
- `if2id_ready`  out  1  ID accepts the upstream instruction this cycle.
- `if2id_pc`  in  XLEN  instruction PC.
- `dec_rs1_addr`, `dec_rs2_addr`  in  RF_AW each  source registers.
- `dec_rs1_rd`, `dec_rs2_rd`  in  1 each  source actually read.
- `dec_reg_waddr`  in  RF_AW  destination register.
- `dec_reg_wen`  in  1  writes a register.
- `dec_mem_rd`  in  1  is a load.
- `dec_ill_instr`  in  1  illegal instruction.
- `dec_ctrl`  in  CTRL_W  remaining decoder outputs, passed through.
- `rf_rs1_data`, `rf_rs2_data`  in  XLEN each  regfile read data.
- `wb_reg_wen`, `wb_reg_waddr`, `wb_reg_wdata`  in  1/RF_AW/XLEN  regfile write port, observed for bypass.
- `fwd_wen`  in  FWD_EXT  external source i will write a register.
- `fwd_waddr`  in  FWD_EXT*RF_AW  source i destination in slice `[i*RF_AW +: RF_AW]`.
- `ex_ready`  in  1  EX accepts the ID/EX entry.
- `id2ex_valid`, `id2ex_pc`, `id2ex_ctrl`, `id2ex_reg_waddr`, `id2ex_reg_wen`, `id2ex_mem_rd`, `id2ex_ill_instr`  out  as inputs  registered entry.
- `id2ex_op1_data`, `id2ex_op2_data`  out  XLEN  registered operand data.
- `id2ex_op1_fwd_sel`, `id2ex_op2_fwd_sel`  out  FWD_EXT+1  one-hot forward select. Bit 0 = the entry currently leaving ID/EX (EX result). Bit i+1 = external source i. All-zero = use op data.

## Operation

- `advance = ~id2ex_valid | ex_ready`.
- `load_stall = if2id_valid & id2ex_valid & id2ex_mem_rd & id2ex_reg_wen & (id2ex_reg_waddr != 0) & ((dec_rs1_rd & dec_rs1_addr == id2ex_reg_waddr) | (dec_rs2_rd & dec_rs2_addr == id2ex_reg_waddr))`.
- `if2id_ready = id_flush | (advance & ~load_stall)`.
- Register update has three cases:
  - Capture: `advance & if2id_valid & ~load_stall & ~id_flush`. Capture everything and set `id2ex_valid=1`.
  - Bubble: `advance` otherwise. Write `id2ex_valid=0`, `reg_wen=0`, `mem_rd=0`, `ill_instr=0`, fwd_sel=0. Other fields are don't-care.
  - Hold: `~advance`. All registers hold.
- An illegal instruction is captured valid with `id2ex_ill_instr=1`. `reg_wen` and `mem_rd` are forced to 0.
- Forward sel, per operand with address a and read flag r. A candidate requires `r & a != 0 & address match`. Priority is bit 0 first, then external index 0 upward. Only the highest-priority match is set.
  - Bit 0 candidate: `id2ex_valid & id2ex_reg_wen & a == id2ex_reg_waddr`.
  - Bit i+1 candidate: `fwd_wen[i] & a == fwd_waddr slice i`.
- While `ex_ready=0` the whole back end is frozen. The `fwd_*` inputs are stable, so the held sel stays correct.

## Timing

- Latency is 1 cycle from accepted handshake to `id2ex_valid`.
- A load-use hazard with `ex_ready=1` inserts exactly one bubble. The dependent instruction is accepted the following cycle with fwd_sel bit 1 set.
- `id_flush` has top priority over stall and hold:
  - It drops the incoming instruction.
  - It does not kill a valid held ID/EX entry when `~advance`.
- Reset: every `id2ex_*` output is 0 one cycle after `rst` is sampled high. `if2id_ready` follows its equation (1 when `id2ex_valid=0`). Reset mid-stall discards the held entry.

## Configuration

- `ID_WB_BYPASS_EN` defined: if `wb_reg_wen & wb_reg_waddr == dec_rsN_addr & dec_rsN_addr != 0`, captured `id2ex_opN_data = wb_reg_wdata`. This covers a regfile that reads before write.
- Not defined: `id2ex_opN_data = rf_rsN_data` unconditionally.

## Test plan

- Reset with `if2id_valid=1` → cycle after reset release: `id2ex_valid=0`, all sel 0, `if2id_ready=1`.
- `lw x5` then `add x6,x5,x7` back-to-back, `ex_ready=1` → one bubble (`id2ex_valid=0`), then add captured with `op1_fwd_sel=3'b010`, `op2_fwd_sel=0`.
- `addi x3` in ID/EX, `fwd_wen=2'b11`, `fwd_waddr` both 3, next reads x3 → `op1_fwd_sel=3'b001` (bit 0 wins). Same with rs=x0 → sel 0.
- `ex_ready=0` for 3 cycles with a valid entry → `if2id_ready=0`, outputs unchanged. `ex_ready=1` → next instruction captured.
- `id_flush=1` with `if2id_valid=1`, `ex_ready=1` → `if2id_ready=1`, next `id2ex_valid=0`. Illegal instruction → `id2ex_valid=1`, `ill_instr=1`, `reg_wen=0`.
- With `ID_WB_BYPASS_EN`: `wb_reg_wen=1`, waddr 9, wdata 0xDEADBEEF, rs1=x9, `rf_rs1_data=0` → `id2ex_op1_data=0xDEADBEEF`. Without the macro → 0.

Source files
------------

// File: rtl/id_stage_hs.sv
`default_nettype none
// ============================================================================
// Module      : id_stage_hs
// Description : ID/EX register with valid/ready handshake, one-hot
//               multi-source forward select, load-use bubble and flush.
//               Optional macro ID_WB_BYPASS_EN enables the write-back bypass.
// Revision    : 1.0
// ============================================================================
module id_stage_hs #(
    parameter int XLEN    = 32,
    parameter int RF_AW   = 5,
    parameter int FWD_EXT = 2,
    parameter int CTRL_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_flush,
    input  logic                     if2id_valid,
    output logic                     if2id_ready,
    input  logic [XLEN-1:0]          if2id_pc,
    input  logic [RF_AW-1:0]         dec_rs1_addr,
    input  logic [RF_AW-1:0]         dec_rs2_addr,
    input  logic                     dec_rs1_rd,
    input  logic                     dec_rs2_rd,
    input  logic [RF_AW-1:0]         dec_reg_waddr,
    input  logic                     dec_reg_wen,
    input  logic                     dec_mem_rd,
    input  logic                     dec_ill_instr,
    input  logic [CTRL_W-1:0]        dec_ctrl,
    input  logic [XLEN-1:0]          rf_rs1_data,
    input  logic [XLEN-1:0]          rf_rs2_data,
    input  logic                     wb_reg_wen,
    input  logic [RF_AW-1:0]         wb_reg_waddr,
    input  logic [XLEN-1:0]          wb_reg_wdata,
    input  logic [FWD_EXT-1:0]       fwd_wen,
    input  logic [FWD_EXT*RF_AW-1:0] fwd_waddr,
    input  logic                     ex_ready,
    output logic                     id2ex_valid,
    output logic [XLEN-1:0]          id2ex_pc,
    output logic [CTRL_W-1:0]        id2ex_ctrl,
    output logic [RF_AW-1:0]         id2ex_reg_waddr,
    output logic                     id2ex_reg_wen,
    output logic                     id2ex_mem_rd,
    output logic                     id2ex_ill_instr,
    output logic [XLEN-1:0]          id2ex_op1_data,
    output logic [XLEN-1:0]          id2ex_op2_data,
    output logic [FWD_EXT:0]         id2ex_op1_fwd_sel,
    output logic [FWD_EXT:0]         id2ex_op2_fwd_sel
);

    logic            w_advance;
    logic            w_load_stall;
    logic            w_capture;
    logic [XLEN-1:0] w_op1_data;
    logic [XLEN-1:0] w_op2_data;

    assign w_advance    = ~id2ex_valid | ex_ready;
    assign w_load_stall = if2id_valid & id2ex_valid & id2ex_mem_rd & id2ex_reg_wen &
                          (id2ex_reg_waddr != '0) &
                          ((dec_rs1_rd & (dec_rs1_addr == id2ex_reg_waddr)) |
                           (dec_rs2_rd & (dec_rs2_addr == id2ex_reg_waddr)));
    assign if2id_ready  = id_flush | (w_advance & ~w_load_stall);
    assign w_capture    = w_advance & if2id_valid & ~w_load_stall & ~id_flush;

`ifdef ID_WB_BYPASS_EN
    // Regfile reads before it writes, so a same-cycle WB value must be bypassed here
    assign w_op1_data = (wb_reg_wen && (wb_reg_waddr == dec_rs1_addr) && (dec_rs1_addr != '0))
                        ? wb_reg_wdata : rf_rs1_data;
    assign w_op2_data = (wb_reg_wen && (wb_reg_waddr == dec_rs2_addr) && (dec_rs2_addr != '0))
                        ? wb_reg_wdata : rf_rs2_data;
`else
    logic w_unused_wb;
    assign w_unused_wb = ^{wb_reg_wen, wb_reg_waddr, wb_reg_wdata};
    assign w_op1_data  = rf_rs1_data;
    assign w_op2_data  = rf_rs2_data;
`endif

    logic [RF_AW-1:0] w_src_addr [2];
    logic             w_src_rd   [2];

    assign w_src_addr[0] = dec_rs1_addr;
    assign w_src_addr[1] = dec_rs2_addr;
    assign w_src_rd[0]   = dec_rs1_rd;
    assign w_src_rd[1]   = dec_rs2_rd;

    // Bit 0 (EX result) beats every external source; lower external index beats higher
    for (genvar g = 0; g < 2; g++) begin : g_fwd_op
        logic [FWD_EXT:0] w_sel;
        logic             w_found;
        always_comb begin
            w_sel   = '0;
            w_found = 1'b0;
            if (w_src_rd[g] && (w_src_addr[g] != '0)) begin
                if (id2ex_valid && id2ex_reg_wen && (w_src_addr[g] == id2ex_reg_waddr)) begin
                    w_sel[0] = 1'b1;
                    w_found  = 1'b1;
                end
                for (int i = 0; i < FWD_EXT; i++) begin
                    if (!w_found && fwd_wen[i] &&
                        (w_src_addr[g] == fwd_waddr[i*RF_AW +: RF_AW])) begin
                        w_sel[i+1] = 1'b1;
                        w_found    = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id2ex_valid       <= 1'b0;
            id2ex_pc          <= '0;
            id2ex_ctrl        <= '0;
            id2ex_reg_waddr   <= '0;
            id2ex_reg_wen     <= 1'b0;
            id2ex_mem_rd      <= 1'b0;
            id2ex_ill_instr   <= 1'b0;
            id2ex_op1_data    <= '0;
            id2ex_op2_data    <= '0;
            id2ex_op1_fwd_sel <= '0;
            id2ex_op2_fwd_sel <= '0;
        end else if (w_advance) begin
            if (w_capture) begin
                id2ex_valid       <= 1'b1;
                id2ex_pc          <= if2id_pc;
                id2ex_ctrl        <= dec_ctrl;
                id2ex_reg_waddr   <= dec_reg_waddr;
                id2ex_reg_wen     <= dec_reg_wen & ~dec_ill_instr;
                id2ex_mem_rd      <= dec_mem_rd & ~dec_ill_instr;
                id2ex_ill_instr   <= dec_ill_instr;
                id2ex_op1_data    <= w_op1_data;
                id2ex_op2_data    <= w_op2_data;
                id2ex_op1_fwd_sel <= g_fwd_op[0].w_sel;
                id2ex_op2_fwd_sel <= g_fwd_op[1].w_sel;
            end else begin
                id2ex_valid       <= 1'b0;
                id2ex_reg_wen     <= 1'b0;
                id2ex_mem_rd      <= 1'b0;
                id2ex_ill_instr   <= 1'b0;
                id2ex_op1_fwd_sel <= '0;
                id2ex_op2_fwd_sel <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_stage_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_stage_hs
// Description : Directed self-checking bench for id_stage_hs.
// Revision    : 1.0
// ============================================================================
module tb_id_stage_hs;

    localparam int XLEN    = 32;
    localparam int RF_AW   = 5;
    localparam int FWD_EXT = 2;
    localparam int CTRL_W  = 32;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     id_flush;
    logic                     if2id_valid;
    logic                     if2id_ready;
    logic [XLEN-1:0]          if2id_pc;
    logic [RF_AW-1:0]         dec_rs1_addr, dec_rs2_addr;
    logic                     dec_rs1_rd, dec_rs2_rd;
    logic [RF_AW-1:0]         dec_reg_waddr;
    logic                     dec_reg_wen, dec_mem_rd, dec_ill_instr;
    logic [CTRL_W-1:0]        dec_ctrl;
    logic [XLEN-1:0]          rf_rs1_data, rf_rs2_data;
    logic                     wb_reg_wen;
    logic [RF_AW-1:0]         wb_reg_waddr;
    logic [XLEN-1:0]          wb_reg_wdata;
    logic [FWD_EXT-1:0]       fwd_wen;
    logic [FWD_EXT*RF_AW-1:0] fwd_waddr;
    logic                     ex_ready;
    logic                     id2ex_valid;
    logic [XLEN-1:0]          id2ex_pc;
    logic [CTRL_W-1:0]        id2ex_ctrl;
    logic [RF_AW-1:0]         id2ex_reg_waddr;
    logic                     id2ex_reg_wen, id2ex_mem_rd, id2ex_ill_instr;
    logic [XLEN-1:0]          id2ex_op1_data, id2ex_op2_data;
    logic [FWD_EXT:0]         id2ex_op1_fwd_sel, id2ex_op2_fwd_sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_stage_hs #(.XLEN(XLEN), .RF_AW(RF_AW), .FWD_EXT(FWD_EXT), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst(rst), .id_flush(id_flush),
        .if2id_valid(if2id_valid), .if2id_ready(if2id_ready), .if2id_pc(if2id_pc),
        .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
        .dec_rs1_rd(dec_rs1_rd), .dec_rs2_rd(dec_rs2_rd),
        .dec_reg_waddr(dec_reg_waddr), .dec_reg_wen(dec_reg_wen),
        .dec_mem_rd(dec_mem_rd), .dec_ill_instr(dec_ill_instr), .dec_ctrl(dec_ctrl),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .wb_reg_wen(wb_reg_wen), .wb_reg_waddr(wb_reg_waddr), .wb_reg_wdata(wb_reg_wdata),
        .fwd_wen(fwd_wen), .fwd_waddr(fwd_waddr), .ex_ready(ex_ready),
        .id2ex_valid(id2ex_valid), .id2ex_pc(id2ex_pc), .id2ex_ctrl(id2ex_ctrl),
        .id2ex_reg_waddr(id2ex_reg_waddr), .id2ex_reg_wen(id2ex_reg_wen),
        .id2ex_mem_rd(id2ex_mem_rd), .id2ex_ill_instr(id2ex_ill_instr),
        .id2ex_op1_data(id2ex_op1_data), .id2ex_op2_data(id2ex_op2_data),
        .id2ex_op1_fwd_sel(id2ex_op1_fwd_sel), .id2ex_op2_fwd_sel(id2ex_op2_fwd_sel)
    );

    // Advance one clock; inputs change and outputs are sampled 1 unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [XLEN-1:0] pc,
                             input logic [RF_AW-1:0] rs1, input logic rs1_rd,
                             input logic [RF_AW-1:0] rs2, input logic rs2_rd,
                             input logic [RF_AW-1:0] rd, input logic wen,
                             input logic mem, input logic ill);
        if2id_valid   = 1'b1;
        if2id_pc      = pc;
        dec_rs1_addr  = rs1;
        dec_rs1_rd    = rs1_rd;
        dec_rs2_addr  = rs2;
        dec_rs2_rd    = rs2_rd;
        dec_reg_waddr = rd;
        dec_reg_wen   = wen;
        dec_mem_rd    = mem;
        dec_ill_instr = ill;
        dec_ctrl      = pc ^ 32'hA5A5_0000;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_instr(32'h0000_0040, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
        #1;
        checks++; if (id2ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", id2ex_valid); end
        checks++; if (id2ex_op1_fwd_sel !== 3'b000) begin errors++; $display("FAIL reset_op1_sel got %b want 000", id2ex_op1_fwd_sel); end
        checks++; if (id2ex_op2_fwd_sel !== 3'b000) begin errors++; $display("FAIL reset_op2_sel got %b want 000", id2ex_op2_fwd_sel); end
        checks++; if (if2id_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", if2id_ready); end
        checks++; if (id2ex_pc !== 32'h0 || id2ex_reg_wen !== 1'b0) begin errors++; $display("FAIL reset_fields got pc %h wen %b want 0/0", id2ex_pc, id2ex_reg_wen); end
        if2id_valid = 1'b0;
        step();
    endtask

    task automatic test_load_use();
        // lw x5, 0(x1)
        set_instr(32'h0000_0100, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        step();
        checks++; if (id2ex_valid !== 1'b1 || id2ex_mem_rd !== 1'b1 || id2ex_reg_waddr !== 5'd5) begin
            errors++; $display("FAIL lw_capture got v%b m%b rd%0d want v1 m1 rd5", id2ex_valid, id2ex_mem_rd, id2ex_reg_waddr); end
        // add x6, x5, x7
        set_instr(32'h0000_0104, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        checks++; if (if2id_ready !== 1'b0) begin errors++; $display("FAIL load_stall_ready got %b want 0", if2id_ready); end
        step();
        checks++; if (id2ex_valid !== 1'b0) begin errors++; $display("FAIL load_bubble got %b want 0", id2ex_valid); end
        fwd_wen   = 2'b01;
        fwd_waddr = {5'd0, 5'd5};
        #1;
        checks++; if (if2id_ready !== 1'b1) begin errors++; $display("FAIL post_bubble_ready got %b want 1", if2id_ready); end
        step();
        checks++; if (id2ex_valid !== 1'b1 || id2ex_pc !== 32'h0000_0104) begin
            errors++; $display("FAIL add_capture got v%b pc %h want v1 pc 00000104", id2ex_valid, id2ex_pc); end
        checks++; if (id2ex_op1_fwd_sel !== 3'b010) begin errors++; $display("FAIL add_op1_sel got %b want 010", id2ex_op1_fwd_sel); end
        checks++; if (id2ex_op2_fwd_sel !== 3'b000) begin errors++; $display("FAIL add_op2_sel got %b want 000", id2ex_op2_fwd_sel); end
        if2id_valid = 1'b0;
        fwd_wen     = 2'b00;
        step();
    endtask

    task automatic test_fwd_priority();
        // addi x3, x1, imm
        set_instr(32'h0000_0200, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        step();
        fwd_wen   = 2'b11;
        fwd_waddr = {5'd3, 5'd3};
        set_instr(32'h0000_0204, 5'd3, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        checks++; if (id2ex_op1_fwd_sel !== 3'b001) begin errors++; $display("FAIL ex_priority_sel got %b want 001", id2ex_op1_fwd_sel); end
        checks++; if (id2ex_op2_fwd_sel !== 3'b000) begin errors++; $display("FAIL x0_sel got %b want 000", id2ex_op2_fwd_sel); end
        // entry in ID/EX writes nothing; external index 0 beats index 1, index 1 alone selects bit 2
        fwd_waddr = {5'd8, 5'd4};
        set_instr(32'h0000_0208, 5'd4, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (id2ex_op1_fwd_sel !== 3'b010) begin errors++; $display("FAIL ext0_sel got %b want 010", id2ex_op1_fwd_sel); end
        checks++; if (id2ex_op2_fwd_sel !== 3'b100) begin errors++; $display("FAIL ext1_sel got %b want 100", id2ex_op2_fwd_sel); end
        fwd_waddr = {5'd4, 5'd4};
        set_instr(32'h0000_020C, 5'd4, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        checks++; if (id2ex_op1_fwd_sel !== 3'b010 || id2ex_op2_fwd_sel !== 3'b000) begin
            errors++; $display("FAIL ext_both_and_noread got %b/%b want 010/000", id2ex_op1_fwd_sel, id2ex_op2_fwd_sel); end
        fwd_wen     = 2'b00;
        if2id_valid = 1'b0;
        step();
    endtask

    task automatic test_back_pressure();
        set_instr(32'h0000_0300, 5'd1, 1'b0, 5'd2, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
        step();
        ex_ready = 1'b0;
        set_instr(32'h0000_0304, 5'd1, 1'b0, 5'd2, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (if2id_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d] got %b want 0", i, if2id_ready); end
            step();
            checks++; if (id2ex_valid !== 1'b1 || id2ex_pc !== 32'h0000_0300 || id2ex_reg_waddr !== 5'd10) begin
                errors++; $display("FAIL hold_entry[%0d] got v%b pc %h rd%0d want v1 pc 00000300 rd10", i, id2ex_valid, id2ex_pc, id2ex_reg_waddr); end
        end
        ex_ready = 1'b1;
        #1;
        step();
        checks++; if (id2ex_pc !== 32'h0000_0304 || id2ex_reg_waddr !== 5'd11) begin
            errors++; $display("FAIL release_capture got pc %h rd%0d want 00000304 rd11", id2ex_pc, id2ex_reg_waddr); end
    endtask

    task automatic test_flush_illegal();
        id_flush = 1'b1;
        set_instr(32'h0000_0400, 5'd1, 1'b0, 5'd2, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0);
        checks++; if (if2id_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", if2id_ready); end
        step();
        checks++; if (id2ex_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got %b want 0", id2ex_valid); end
        id_flush = 1'b0;
        set_instr(32'h0000_0404, 5'd1, 1'b0, 5'd2, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0);
        step();
        // flush while EX stalls must not kill the held entry
        ex_ready = 1'b0;
        id_flush = 1'b1;
        set_instr(32'h0000_0408, 5'd1, 1'b0, 5'd2, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0);
        checks++; if (if2id_ready !== 1'b1) begin errors++; $display("FAIL flush_hold_ready got %b want 1", if2id_ready); end
        step();
        checks++; if (id2ex_valid !== 1'b1 || id2ex_pc !== 32'h0000_0404) begin
            errors++; $display("FAIL flush_hold_keep got v%b pc %h want v1 pc 00000404", id2ex_valid, id2ex_pc); end
        id_flush = 1'b0;
        ex_ready = 1'b1;
        set_instr(32'h0000_040C, 5'd1, 1'b0, 5'd2, 1'b0, 5'd15, 1'b1, 1'b1, 1'b1);
        step();
        checks++; if (id2ex_valid !== 1'b1 || id2ex_ill_instr !== 1'b1 || id2ex_reg_wen !== 1'b0 || id2ex_mem_rd !== 1'b0) begin
            errors++; $display("FAIL illegal got v%b ill%b wen%b mem%b want 1 1 0 0", id2ex_valid, id2ex_ill_instr, id2ex_reg_wen, id2ex_mem_rd); end
        if2id_valid = 1'b0;
        step();
    endtask

    task automatic test_bypass();
        logic [XLEN-1:0] exp_op1;
`ifdef ID_WB_BYPASS_EN
        exp_op1 = 32'hDEAD_BEEF;
`else
        exp_op1 = 32'h0000_0000;
`endif
        wb_reg_wen   = 1'b1;
        wb_reg_waddr = 5'd9;
        wb_reg_wdata = 32'hDEAD_BEEF;
        rf_rs1_data  = 32'h0;
        rf_rs2_data  = 32'h0000_1234;
        set_instr(32'h0000_0500, 5'd9, 1'b1, 5'd2, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (id2ex_op1_data !== exp_op1) begin errors++; $display("FAIL wb_bypass_op1 got %h want %h", id2ex_op1_data, exp_op1); end
        checks++; if (id2ex_op2_data !== 32'h0000_1234) begin errors++; $display("FAIL rf_op2 got %h want 00001234", id2ex_op2_data); end
        checks++; if (id2ex_ctrl !== (32'h0000_0500 ^ 32'hA5A5_0000)) begin errors++; $display("FAIL ctrl_pass got %h want a5a50500", id2ex_ctrl); end
        wb_reg_wen  = 1'b0;
        if2id_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_stall();
        set_instr(32'h0000_0600, 5'd1, 1'b0, 5'd2, 1'b0, 5'd17, 1'b1, 1'b0, 1'b0);
        step();
        ex_ready = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++; if (id2ex_valid !== 1'b0 || id2ex_reg_wen !== 1'b0) begin
            errors++; $display("FAIL reset_mid_stall got v%b wen%b want 0 0", id2ex_valid, id2ex_reg_wen); end
        checks++; if (if2id_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_stall_ready got %b want 1", if2id_ready); end
        ex_ready    = 1'b1;
        if2id_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; id_flush = 1'b0; if2id_valid = 1'b0; if2id_pc = '0;
        dec_rs1_addr = '0; dec_rs2_addr = '0; dec_rs1_rd = 1'b0; dec_rs2_rd = 1'b0;
        dec_reg_waddr = '0; dec_reg_wen = 1'b0; dec_mem_rd = 1'b0; dec_ill_instr = 1'b0;
        dec_ctrl = '0; rf_rs1_data = 32'h1111_1111; rf_rs2_data = 32'h2222_2222;
        wb_reg_wen = 1'b0; wb_reg_waddr = '0; wb_reg_wdata = '0;
        fwd_wen = '0; fwd_waddr = '0; ex_ready = 1'b1;
        test_reset();
        test_load_use();
        test_fwd_priority();
        test_back_pressure();
        test_flush_illegal();
        test_bypass();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
